uart_tx_fifo: RTL
=================

# uart_tx_fifo

Transmit-side FIFO that buffers bytes from the host bus and feeds the UART transmit FSM. It presents the head word show-ahead on `rd_data` and drives `d_ready` to the FSM. It pops the head word when the FSM commits a frame, detected as a rising edge on the FSM's `tr_bz`. It also reports occupancy, full/empty, and sticky overflow to the host.

## Interface
- `WIDTH`, 8, data bits per word; must match the transmit FSM's `WIDTH`.
- `DEPTH`, 16, number of entries; power of two, ≥ 2.
- `AW`, `$clog2(DEPTH)`, pointer width; derived, not overridden.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous assert, active-low.
- `wr_en`  in  1  host push strobe, one word per cycle while high.
- `wr_data`  in  WIDTH  host push data.
- `full`  out  1  registered; high when count == DEPTH.
- `empty`  out  1  registered; high when count == 0.
- `count`  out  AW+1  registered occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; set by a push attempted while `full`.
- `ovf_clr`  in  1  synchronous clear of `overflow`.
- `tr_bz`  in  1  busy flag from the transmit FSM; its 0→1 edge pops.
- `d_ready`  out  1  to the FSM; equals `~empty`.
- `rd_data`  out  WIDTH  head word, `mem[rd_ptr]`, show-ahead.
- `rd_parity`  out  1  even parity of the head word; see Configuration.

## Operation
- Storage is `DEPTH` × `WIDTH` registers, with `wr_ptr` and `rd_ptr` of width AW that wrap naturally modulo DEPTH.
- Push:
  - A push is accepted when `wr_en & ~full`.
  - It writes `mem[wr_ptr]` and increments `wr_ptr`.
- Rejected push: `wr_en & full` leaves the contents, pointers and count unchanged and sets `overflow`.
- Pop detection:
  - `tr_bz_q` registers `tr_bz`.
  - `pop_req = tr_bz & ~tr_bz_q`.
  - A pop is accepted when `pop_req & ~empty`; it increments `rd_ptr`.
  - A `pop_req` while empty is ignored; no flag is raised.
- Count update: count +1 on an accepted push only, −1 on an accepted pop only, unchanged when both or neither occur.
- `full` and `empty` are recomputed from the next count and registered together with it.
- `full` is sampled pre-edge:
  - A push while full is rejected even if a pop is accepted in the same cycle.
  - A push and a pop when count == 1 both succeed; count stays 1 and `rd_data` shows the new word on the next cycle.
- `overflow`:
  - Set has priority over `ovf_clr` in the same cycle.
  - Otherwise `ovf_clr` clears it.
- `rd_data` is a combinational read of `mem[rd_ptr]`. It holds stable from the cycle `d_ready` rises until the cycle after the popping edge, which covers the FSM's IDLE `data_load` window.

## Timing
- Reset values:
  - `wr_ptr`, `rd_ptr`, `count` = 0.
  - `empty` = 1, `full` = 0, `d_ready` = 0.
  - `overflow` = 0, `tr_bz_q` = 0.
  - `rd_data` and `mem` are don't-care; `rd_parity` is don't-care after reset.
- Push latency: a push accepted at edge N gives `empty` = 0 and `d_ready` = 1 after edge N, with `rd_data` valid in the same cycle.
- Pop latency: `tr_bz` high in cycle C means `rd_ptr` advances at the end of C, and the next word (or `empty`) is visible in C+1.
- A `tr_bz` held high for multiple cycles pops exactly once. `tr_bz` must fall and rise again to pop the next word.
- Reset mid-operation:
  - The FIFO is emptied asynchronously, and the stored words are lost.
  - A `tr_bz` high at reset release produces a pop edge into an empty FIFO, which is ignored.
- Throughput: one push per cycle; at most one pop per frame.

## Configuration
- Macro `UART_TXF_PARITY_EN`:
  - Defined: `rd_parity` = XOR reduction of `rd_data`, combinational and valid whenever `d_ready` = 1. This feeds the FSM's PARITY state.
  - Undefined: `rd_parity` is tied to 0 and no XOR tree is synthesized; the port remains present.

## Test plan
- Reset, then push 0xA5 → next cycle: `d_ready` = 1, `rd_data` = 0xA5, `count` = 1, `empty` = 0.
- Push 16 words 0x00..0x0F, then push 0xFF → `full` = 1, `count` = 16, `overflow` = 1, 0xFF not stored; `ovf_clr` pulse → `overflow` = 0.
- With 3 words stored, hold `tr_bz` high for 10 cycles → exactly one pop, `count` = 2, `rd_data` = second word.
- With count = 1, push 0x3C in the same cycle as the `tr_bz` rising edge → `count` stays 1, `rd_data` = 0x3C next cycle. Repeat with the FIFO full → push rejected, `count` = 15, `overflow` = 1.
- Wrap-around: push/pop 40 words 0x00..0x27 interleaved → output sequence identical to the input order, `empty` = 1 at the end.
- With `UART_TXF_PARITY_EN` defined, head 0x07 → `rd_parity` = 1 and head 0x03 → `rd_parity` = 0. Without the macro, `rd_parity` = 0. Assert `rstn` low mid-stream → `empty` = 1 and `count` = 0 immediately.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Show-ahead transmit FIFO between the host bus and the UART TX FSM; pops on a tr_bz rising edge.
// Define UART_TXF_PARITY_EN to drive even parity of the head word on rd_parity.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             overflow,
    input  logic             ovf_clr,
    input  logic             tr_bz,
    output logic             d_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_parity
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_next;
    logic             tr_bz_q;
    logic             pop_req;
    logic             push_ok;
    logic             pop_ok;

    // full/empty are the registered pre-edge view, so a push into a full FIFO
    // is refused even when a pop frees a slot in the same cycle.
    assign pop_req = tr_bz & ~tr_bz_q;
    assign push_ok = wr_en & ~full;
    assign pop_ok  = pop_req & ~empty;

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + (AW + 1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_next = count - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            tr_bz_q  <= 1'b0;
        end else begin
            tr_bz_q <= tr_bz;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == FULL_COUNT);
            empty <= (count_next == '0);
            // A rejected push in the same cycle as a clear keeps the flag set.
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage has no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];
    assign d_ready = ~empty;

`ifdef UART_TXF_PARITY_EN
    assign rd_parity = ^rd_data;
`else
    assign rd_parity = 1'b0;
`endif

endmodule
